// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB initiator signals for apb_master_bridge.
// master = bridge view; slave = requester + APB target view.
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-beat command -> APB SETUP/ACCESS initiator; response pulse 3+waits cycles after accept.
// cmd_ready only in IDLE; slave stalls via PREADY, aborted after TIMEOUT_CYCLES waits (0 = never).
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_master_bridge_if.master bus_io
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                state_q,       state_d;
    logic                  cmd_ready_q,   cmd_ready_d;
    logic                  psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic                  pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                if (bus_io.cmd_valid && cmd_ready_q) begin
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = bus_io.cmd_write;
                    paddr_d     = bus_io.cmd_addr;
                    pwdata_d    = bus_io.cmd_wdata;
                    wait_cnt_d  = '0;
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                if (bus_io.PREADY) begin
                    state_d       = ST_IDLE;
                    cmd_ready_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : bus_io.PRDATA;
                    rsp_err_d     = bus_io.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (TMO_EN && (wait_cnt_q == CNT_LIMIT)) begin
                    // Slave stalled too long: abandon the transfer and report it.
                    state_d       = ST_IDLE;
                    cmd_ready_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign bus_io.cmd_ready   = cmd_ready_q;
    assign bus_io.PSEL        = psel_q;
    assign bus_io.PENABLE     = penable_q;
    assign bus_io.PWRITE      = pwrite_q;
    assign bus_io.PADDR       = paddr_q;
    assign bus_io.PWDATA      = pwdata_q;
    assign bus_io.rsp_valid   = rsp_valid_q;
    assign bus_io.rsp_rdata   = rsp_rdata_q;
    assign bus_io.rsp_err     = rsp_err_q;
    assign bus_io.rsp_timeout = rsp_timeout_q;

endmodule
